// File: rtl/lcd_text_refresher.sv
// lcd_text_refresher: ROWSxCOLS character buffer; HD44780 init once, then re-sends only the rows that changed.
// Latency: a write seen in IDLE raises oStart for the row command 2 cycles later; each byte costs ISSUE + controller + 1 + DLY_CYCLES.
// Backpressure: host writes are never stalled; bytes advance only when the controller returns iDone.
// Ports: iCLK / iRST_N (async, active-low) clock and reset; iWR / iADDR / iCHAR host character write (iADDR = row*COLS+col);
//        oDATA / oRS / oStart / iDone byte handshake to LCD_Controller; oBusy high outside IDLE; oInitDone sticky after init.
// Option: define LCD_AUTO_REFRESH_EN to mark every row dirty once per REFRESH_CYCLES cycles.
module lcd_text_refresher #(
    parameter int COLS           = 16,
    parameter int ROWS           = 2,
    parameter int DLY_CYCLES     = 262142,
    parameter int REFRESH_CYCLES = 50_000_000,
    parameter int AW             = $clog2(ROWS * COLS)
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic          iWR,
    input  logic [AW-1:0] iADDR,
    input  logic [7:0]    iCHAR,
    output logic          oBusy,
    output logic          oInitDone,
    output logic [7:0]    oDATA,
    output logic          oRS,
    output logic          oStart,
    input  logic          iDone
);

    localparam int NCH = ROWS * COLS;
    localparam int BW  = (NCH > 1) ? $clog2(NCH) : 1;     // buffer index width
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;   // row index width
    localparam int IW  = (COLS > 4) ? $clog2(COLS) : 2;   // byte index: init commands 0..3 or columns
    localparam int DW  = $clog2(DLY_CYCLES + 2);          // gap counter, counts 0..DLY_CYCLES

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ROWCMD,
        ST_CHARS
    } state_t;

    // PH_LOAD only occurs right after reset: it loads the first init byte.
    // Every later byte is loaded on the edge that leaves the previous GAP (or IDLE),
    // so the ISSUE cycle is the first cycle oStart is high.
    typedef enum logic [1:0] {
        PH_LOAD,
        PH_ISSUE,
        PH_WAIT,
        PH_GAP
    } phase_t;

    function automatic logic [7:0] row_base(input int row);
        case (row)
            0:       row_base = 8'h00;
            1:       row_base = 8'h40;
            2:       row_base = 8'h14;
            default: row_base = 8'h54;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    state_t          r_state;
    phase_t          r_phase;
    logic [IW-1:0]   r_idx;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_dly;
    logic [ROWS-1:0] r_dirty;
    logic [7:0]      r_buf [NCH];
    logic [7:0]      r_data;
    logic            r_rs;
    logic            r_start;
    logic            r_busy;
    logic            r_init_done;

    state_t          w_state;
    phase_t          w_phase;
    logic [IW-1:0]   w_idx;
    logic [RW-1:0]   w_row;
    logic [DW-1:0]   w_dly;
    logic            w_start;
    logic            w_busy;
    logic            w_init_done;
    logic            w_load;
    logic [ROWS-1:0] w_clr;
    logic [ROWS-1:0] w_set;
    logic [ROWS-1:0] w_wr_oh;
    logic            w_wr_ok;
    logic [BW-1:0]   w_wr_idx;
    logic [BW-1:0]   w_rd_idx;
    logic [RW-1:0]   w_pick;
    logic [ROWS-1:0] w_pick_oh;
    logic            w_any_dirty;
    logic [7:0]      w_byte_data;
    logic            w_byte_rs;
    logic            w_ref_tick;

    // ---------------------------------------------------------------- host write decode
    always_comb begin
        w_wr_ok  = iWR && (int'(iADDR) < NCH);
        w_wr_idx = BW'(iADDR);
        w_wr_oh  = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_wr_oh[r] = w_wr_ok && ((int'(iADDR) / COLS) == r);
        end
    end

    // ---------------------------------------------------------------- auto refresh
`ifdef LCD_AUTO_REFRESH_EN
    localparam int CW = $clog2(REFRESH_CYCLES + 1);
    logic [CW-1:0] r_ref_cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_ref_cnt <= '0;
        end else if (w_ref_tick) begin
            r_ref_cnt <= '0;
        end else begin
            r_ref_cnt <= r_ref_cnt + CW'(1);
        end
    end

    assign w_ref_tick = (r_ref_cnt == CW'(REFRESH_CYCLES - 1));
`else
    // No periodic refresh in this build; the parameter has no effect.
    assign w_ref_tick = (REFRESH_CYCLES < 0);
`endif

    // A refresh tick marks every row; a row already being sent still finishes first.
    assign w_set = w_wr_oh | {ROWS{w_ref_tick}};

    // ---------------------------------------------------------------- buffer and dirty flags
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NCH; i++) begin
                r_buf[i] <= 8'h20;
            end
            r_dirty <= '1;
        end else begin
            if (w_wr_ok) begin
                r_buf[w_wr_idx] <= iCHAR;
            end
            // Set after clear: a write that lands on the row being picked keeps it dirty.
            r_dirty <= (r_dirty & ~w_clr) | w_set;
        end
    end

    // Lowest-index dirty row.
    always_comb begin
        w_any_dirty = |r_dirty;
        w_pick      = '0;
        w_pick_oh   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (r_dirty[r]) begin
                w_pick       = RW'(r);
                w_pick_oh    = '0;
                w_pick_oh[r] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        w_state     = r_state;
        w_phase     = r_phase;
        w_idx       = r_idx;
        w_row       = r_row;
        w_dly       = r_dly;
        w_start     = r_start;
        w_busy      = r_busy;
        w_init_done = r_init_done;
        w_clr       = '0;
        w_load      = 1'b0;

        if (r_state == ST_IDLE) begin
            if (w_any_dirty) begin
                w_state = ST_ROWCMD;
                w_row   = w_pick;
                w_idx   = '0;
                w_clr   = w_pick_oh;
                w_busy  = 1'b1;
                w_load  = 1'b1;
            end
        end else begin
            case (r_phase)
                PH_LOAD: begin
                    w_load = 1'b1;
                end
                PH_ISSUE, PH_WAIT: begin
                    // oStart is high in both phases, so iDone is honoured in either.
                    if (iDone) begin
                        w_start = 1'b0;
                        w_phase = PH_GAP;
                        w_dly   = '0;
                    end else begin
                        w_phase = PH_WAIT;
                    end
                end
                default: begin
                    if (r_dly == DW'(DLY_CYCLES)) begin
                        w_dly = '0;
                        case (r_state)
                            ST_INIT: begin
                                if (r_idx == IW'(3)) begin
                                    w_state     = ST_IDLE;
                                    w_idx       = '0;
                                    w_busy      = 1'b0;
                                    w_init_done = 1'b1;
                                end else begin
                                    w_idx  = r_idx + IW'(1);
                                    w_load = 1'b1;
                                end
                            end
                            ST_ROWCMD: begin
                                w_state = ST_CHARS;
                                w_idx   = '0;
                                w_load  = 1'b1;
                            end
                            default: begin
                                if (r_idx == IW'(COLS - 1)) begin
                                    w_state = ST_IDLE;
                                    w_idx   = '0;
                                    w_busy  = 1'b0;
                                end else begin
                                    w_idx  = r_idx + IW'(1);
                                    w_load = 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        w_dly = r_dly + DW'(1);
                    end
                end
            endcase
        end

        if (w_load) begin
            w_phase = PH_ISSUE;
            w_start = 1'b1;
        end
    end

    // ---------------------------------------------------------------- byte about to be issued
    always_comb begin
        w_rd_idx    = BW'(int'(w_row) * COLS + int'(w_idx));
        w_byte_data = 8'h00;
        w_byte_rs   = 1'b0;
        case (w_state)
            ST_INIT: begin
                if (w_idx == IW'(0)) begin
                    w_byte_data = 8'h38;        // 8-bit bus, 2 lines, 5x8 font
                end else if (w_idx == IW'(1)) begin
                    w_byte_data = 8'h0C;        // display on, cursor off
                end else if (w_idx == IW'(2)) begin
                    w_byte_data = 8'h01;        // clear
                end else begin
                    w_byte_data = 8'h06;        // entry mode: increment, no shift
                end
            end
            ST_ROWCMD: begin
                w_byte_data = 8'h80 | row_base(int'(w_row));
            end
            ST_CHARS: begin
                w_byte_data = r_buf[w_rd_idx];
                w_byte_rs   = 1'b1;
            end
            default: begin
                w_byte_data = 8'h00;
            end
        endcase
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_INIT;
            r_phase     <= PH_LOAD;
            r_idx       <= '0;
            r_row       <= '0;
            r_dly       <= '0;
            r_data      <= 8'h00;
            r_rs        <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_phase     <= w_phase;
            r_idx       <= w_idx;
            r_row       <= w_row;
            r_dly       <= w_dly;
            r_start     <= w_start;
            r_busy      <= w_busy;
            r_init_done <= w_init_done;
            if (w_load) begin
                r_data <= w_byte_data;
                r_rs   <= w_byte_rs;
            end
        end
    end

    assign oDATA     = r_data;
    assign oRS       = r_rs;
    assign oStart    = r_start;
    assign oBusy     = r_busy;
    assign oInitDone = r_init_done;

endmodule
